// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access unit.
// Holds access-size codes, the FSM state type and the lane-select constants.
package mem_access_unit_pkg;

    localparam int MEM_WORDS_DEF = 3073;
    localparam int ADDR_HI_DEF   = 13;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERR     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WORD_WR = 3'd3,
        ST_RMW_RD  = 3'd4,
        ST_RMW_WR  = 3'd5
    } state_e;

    localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;

    // Bit offset of byte lane k inside a little-endian word.
    function automatic logic [4:0] lane_shift(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane logic: extracts/extends load data from a word and merges
// sub-word store data into an existing word (little-endian lanes).
module lsu_lane
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] byte_mask;
    logic [31:0] byte_ins;

    always_comb begin
        shifted   = word_i >> lane_shift(off_i);
        byte_v    = shifted[7:0];
        half_v    = off_i[1] ? word_i[31:16] : word_i[15:0];
        byte_mask = BYTE_LANE_MASK << lane_shift(off_i);
        byte_ins  = {24'd0, wdata_i[7:0]} << lane_shift(off_i);

        rdata_o  = word_i;
        merged_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                rdata_o  = {{24{signed_i & byte_v[7]}}, byte_v};
                merged_o = (word_i & ~byte_mask) | byte_ins;
            end
            SZ_HALF: begin
                rdata_o  = {{16{signed_i & half_v[15]}}, half_v};
                merged_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                    : {word_i[31:16], wdata_i[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data memory: accepts one load/store,
// turns sub-word stores into read-modify-write and returns data or an error.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int ADDR_HI   = ADDR_HI_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [31:0]          req_pc,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [31:0]          resp_rdata,
    output logic                 mem_we,
    output logic [ADDR_HI-2:0]   mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [31:0]          mem_pc,
    input  logic [31:0]          mem_rdata
);

    localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

    state_e              state_q;
    logic [ADDR_HI-2:0]  idx_q;
    logic [1:0]          off_q;
    size_e               size_q;
    logic                signed_q;
    logic [31:0]         wdata_q;
    logic [31:0]         pc_q;
    logic                mem_we_q;
    logic [31:0]         mem_wdata_q;
    logic                resp_valid_q;
    logic                resp_err_q;

    size_e               size_d;
    logic [ADDR_HI-2:0]  idx_d;
    logic                err_d;
    state_e              state_d;

    logic [31:0]         lane_rdata;
    logic [31:0]         lane_merged;

    // Request decode: error classification and the state to enter on accept.
    always_comb begin
        size_d = size_e'(req_size);
        idx_d  = req_addr[ADDR_HI:2];
        err_d  = 1'b0;
        case (size_d)
            SZ_HALF: err_d = req_addr[0];
            SZ_WORD: err_d = (req_addr[1:0] != 2'b00);
            SZ_RSVD: err_d = 1'b1;
            default: ;
        endcase
        if (req_addr[31:ADDR_HI+1] != '0) begin
            err_d = 1'b1;
        end
        if (32'(idx_d) >= MEM_WORDS_U) begin
            err_d = 1'b1;
        end

        if (err_d) begin
            state_d = ST_ERR;
        end else if (!req_write) begin
            state_d = ST_LOAD;
        end else if (size_d == SZ_WORD) begin
            state_d = ST_WORD_WR;
        end else begin
            state_d = ST_RMW_RD;
        end
    end

    lsu_lane u_lane (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .rdata_o  (lane_rdata),
        .merged_o (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            off_q        <= '0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            pc_q         <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_q    <= idx_d;
                        off_q    <= req_addr[1:0];
                        size_q   <= size_d;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata;
                        pc_q     <= req_pc;
                        state_q  <= state_d;
                        case (state_d)
                            ST_ERR: begin
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b1;
                            end
                            ST_LOAD: resp_valid_q <= 1'b1;
                            ST_WORD_WR: begin
                                mem_we_q     <= 1'b1;
                                mem_wdata_q  <= req_wdata;
                                resp_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                // Old word is on mem_rdata now; capture the merge for next cycle's write.
                ST_RMW_RD: begin
                    mem_we_q     <= 1'b1;
                    mem_wdata_q  <= lane_merged;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RMW_WR;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (state_q == ST_LOAD) ? lane_rdata : '0;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_addr   = (state_q != ST_IDLE) ? idx_q : '0;
    assign mem_pc     = (state_q != ST_IDLE) ? pc_q  : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses/writes; a negedge monitor pops and compares them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_pc     (mem_pc),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          c;
        string       nm;
    } resp_t;
    typedef struct {
        logic [11:0] idx;
        logic [31:0] d;
        logic [31:0] pc;
        int          c;
        string       nm;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    int    nchk = 0;
    int    nfail = 0;
    logic [31:0] pc_n = 32'h0000_0400;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        resp_t r;
        wr_t   w;
        if (resp_valid) begin
            if (rq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_resp: got resp_valid=1 (err=%0b) at cycle %0d required none", resp_err, cyc);
            end else begin
                r = rq.pop_front();
                chk({r.nm, "_err"},   32'(resp_err), 32'(r.err));
                chk({r.nm, "_rdata"}, resp_rdata, r.rd);
                chk({r.nm, "_cycle"}, 32'(cyc), 32'(r.c));
                chk({r.nm, "_ready_busy"}, 32'(req_ready), 32'd0);
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_write: got write idx %h data %h at cycle %0d required none", mem_addr, mem_wdata, cyc);
            end else begin
                w = wq.pop_front();
                chk({w.nm, "_widx"},   32'(mem_addr), 32'(w.idx));
                chk({w.nm, "_wdata"},  mem_wdata, w.d);
                chk({w.nm, "_wpc"},    mem_pc, w.pc);
                chk({w.nm, "_wcycle"}, 32'(cyc), 32'(w.c));
            end
        end
    end

    // Drive one request, wait (bounded) for accept, then queue the expectations.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input logic [31:0] e_wd,
                         input string nm, input bit track, output int acc);
        logic  rdy;
        bit    rmw;
        resp_t r;
        wr_t   x;
        @(negedge clk);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_pc     = pc_n;
        req_valid  = 1'b1;
        acc = -1;
        for (int i = 0; i < 16 && acc < 0; i++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = cyc;
            else @(negedge clk);
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            nchk++;
            nfail++;
            $display("FAIL %s_accept: got no accept required accept within 16 cycles", nm);
            return;
        end
        rmw = w && (sz != 2'b10) && !e_err;
        if (track) begin
            r.err = e_err;
            r.rd  = e_rd;
            r.c   = acc + (rmw ? 1 : 0);
            r.nm  = nm;
            rq.push_back(r);
            if (w && !e_err) begin
                x.idx = a[13:2];
                x.d   = e_wd;
                x.pc  = pc_n;
                x.c   = acc + (rmw ? 1 : 0);
                x.nm  = nm;
                wq.push_back(x);
            end
        end
        pc_n = pc_n + 32'd4;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0, a1, a2, a3, a4;
        int t;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ready",  32'(req_ready),  32'd1);
        chk("rst_valid",  32'(resp_valid), 32'd0);
        chk("rst_err",    32'(resp_err),   32'd0);
        chk("rst_rdata",  resp_rdata,      32'd0);
        chk("rst_we",     32'(mem_we),     32'd0);
        chk("rst_maddr",  32'(mem_addr),   32'd0);
        chk("rst_mpc",    mem_pc,          32'd0);

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, "sw_10", 1, t);
        issue(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 32'h11223344, "sw_10b", 1, t);
        issue(1, 2'b00, 0, 32'h12, 32'h000000AA, 0, 0, 32'h11AA3344, "sb_12", 1, t);
        issue(0, 2'b00, 1, 32'h12, 0, 0, 32'hFFFFFFAA, 0, "lb_12", 1, t);
        issue(0, 2'b00, 0, 32'h12, 0, 0, 32'h000000AA, 0, "lbu_12", 1, t);
        issue(0, 2'b01, 1, 32'h12, 0, 0, 32'h000011AA, 0, "lh_12", 1, t);
        issue(0, 2'b10, 0, 32'h10, 0, 0, 32'h11AA3344, 0, "lw_10", 1, t);

        issue(0, 2'b01, 1, 32'h11,   0,          1, 0, 0, "err_lh_11", 1, t);
        issue(1, 2'b10, 0, 32'h2,    32'h5555AAAA, 1, 0, 0, "err_sw_2", 1, t);
        issue(0, 2'b10, 0, 32'h3004, 0,          1, 0, 0, "err_lw_3004", 1, t);
        issue(1, 2'b10, 0, 32'h4000, 32'h5555AAAA, 1, 0, 0, "err_sw_4000", 1, t);
        issue(0, 2'b11, 0, 32'h10,   0,          1, 0, 0, "err_size11", 1, t);
        issue(1, 2'b11, 0, 32'h10,   32'h5555AAAA, 1, 0, 0, "err_st_size11", 1, t);
        issue(0, 2'b10, 0, 32'h10,   0,          0, 32'h11AA3344, 0, "lw_after_err", 1, t);

        issue(1, 2'b10, 0, 32'h3000, 32'h12345678, 0, 0, 32'h12345678, "sw_3000", 1, t);
        issue(1, 2'b01, 0, 32'h3002, 32'hCAFEBEEF, 0, 0, 32'hBEEF5678, "sh_3002", 1, t);
        issue(0, 2'b10, 0, 32'h3000, 0, 0, 32'hBEEF5678, 0, "lw_3000", 1, t);
        issue(0, 2'b01, 1, 32'h3002, 0, 0, 32'hFFFFBEEF, 0, "lh_3002", 1, t);
        issue(0, 2'b00, 0, 32'h3001, 0, 0, 32'h00000056, 0, "lbu_3001", 1, t);
        issue(0, 2'b00, 1, 32'h3003, 0, 0, 32'hFFFFFFBE, 0, "lb_3003", 1, t);
        issue(1, 2'b01, 0, 32'h3000, 32'h00001234, 0, 0, 32'hBEEF1234, "sh_3000", 1, t);

        // Abort a sub-word store while it is reading the old word.
        issue(1, 2'b00, 0, 32'h10, 32'h00000055, 0, 0, 0, "sb_abort", 0, t);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready),  32'd1);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_we",    32'(mem_we),     32'd0);
        chk("abort_maddr", 32'(mem_addr),   32'd0);
        chk("abort_mpc",   mem_pc,          32'd0);
        chk("abort_rdata", resp_rdata,      32'd0);
        issue(0, 2'b10, 0, 32'h10, 0, 0, 32'h11AA3344, 0, "lw_after_abort", 1, t);

        issue(0, 2'b10, 0, 32'h10, 0, 0, 32'h11AA3344, 0, "b2b_lw", 1, a0);
        issue(1, 2'b10, 0, 32'h20, 32'h0BADF00D, 0, 0, 32'h0BADF00D, "b2b_sw", 1, a1);
        issue(1, 2'b00, 0, 32'h21, 32'h00000077, 0, 0, 32'h0BAD770D, "b2b_sb", 1, a2);
        issue(0, 2'b01, 0, 32'h11, 0, 1, 0, 0, "b2b_err", 1, a3);
        issue(0, 2'b10, 0, 32'h20, 0, 0, 32'h0BAD770D, 0, "b2b_lw2", 1, a4);
        chk("space_load", 32'(a1 - a0), 32'd2);
        chk("space_sw",   32'(a2 - a1), 32'd2);
        chk("space_sb",   32'(a3 - a2), 32'd3);
        chk("space_err",  32'(a4 - a3), 32'd2);

        for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_resp",  32'(rq.size()), 32'd0);
        chk("drain_write", 32'(wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
